// File: rtl/crc_sekwencyjny.sv
// Multi-cycle CRC engine: long division of a data word by a runtime generator
// polynomial, retiring BPC dividend bits per cycle; generates or checks a CRC.
module crc_sekwencyjny #(
    parameter int unsigned WCODE = 8,
    parameter int unsigned WPOLY = 4,
    parameter int unsigned BPC   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_mode,
    input  logic [WCODE-1:0]   i_data,
    input  logic [WPOLY-1:0]   i_poly,
    input  logic [WPOLY-2:0]   i_crc,
    output logic               o_busy,
    output logic               o_valid,
    output logic [WPOLY-2:0]   o_crc,
    output logic               o_ok,
    output logic               o_err
);

    localparam int unsigned LEN   = WCODE + WPOLY - 1;
    localparam int unsigned WCRC  = WPOLY - 1;
    localparam int unsigned STEPS = WCODE / BPC;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    generate
        if (WCODE % BPC != 0) begin : g_bad_bpc
            $error("crc_sekwencyjny: BPC must divide WCODE");
        end
        if (WPOLY < 2) begin : g_bad_wpoly
            $error("crc_sekwencyjny: WPOLY must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [LEN-1:0]    r, r_next;
    logic [WPOLY-1:0]  poly_q, poly_next;
    logic              mode_q, mode_next;
    logic              err_q, err_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              busy_next, valid_next;
    logic [WCRC-1:0]   rem_c;
    logic [LEN-1:0]    div_c;

    // BPC cascaded elementary division steps (conditional XOR, then shift)
    function automatic logic [LEN-1:0] div_steps(input logic [LEN-1:0]   r_in,
                                                 input logic [WPOLY-1:0] p);
        logic [LEN-1:0] acc;
        acc = r_in;
        for (int unsigned k = 0; k < BPC; k++) begin
            if (acc[LEN-1]) begin
                acc[LEN-1 -: WPOLY] = acc[LEN-1 -: WPOLY] ^ p;
            end
            acc = acc << 1;
        end
        return acc;
    endfunction

    assign div_c = div_steps(r, poly_q);
    assign rem_c = r[LEN-1 -: WCRC];

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            r      <= '0;
            poly_q <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            r      <= r_next;
            poly_q <= poly_next;
            mode_q <= mode_next;
            err_q  <= err_next;
            cnt    <= cnt_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        r_next     = r;
        poly_next  = poly_q;
        mode_next  = mode_q;
        err_next   = err_q;
        cnt_next   = cnt;
        valid_next = 1'b0;

        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    poly_next = i_poly;
                    mode_next = i_mode;
                    r_next    = {i_data, i_mode ? i_crc : WCRC'(0)};
                    cnt_next  = CW'(STEPS);
                    if (!i_poly[WPOLY-1]) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else begin
                    r_next   = div_c;
                    cnt_next = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                valid_next = !i_abort;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // busy stays up through the result cycle, so it drops one edge after o_valid rises
        busy_next = (state_next != IDLE) || valid_next;
    end

    // Registered result outputs; results only change on a completed operation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_crc   <= '0;
            o_ok    <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_busy  <= busy_next;
            o_valid <= valid_next;
            if (valid_next) begin
                o_crc <= err_q ? WCRC'(0) : rem_c;
                o_ok  <= mode_q & (rem_c == WCRC'(0)) & ~err_q;
                o_err <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_crc_sekwencyjny.sv
// Self-checking bench for crc_sekwencyjny: four instances (BPC = 1,2,4,8) checked
// against a polynomial long-division reference model and fixed vectors.
module tb_crc_sekwencyjny;

    localparam int unsigned WCODE = 8;
    localparam int unsigned WPOLY = 4;
    localparam int unsigned ND    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort_s;
    logic       mode;
    logic [7:0] data;
    logic [3:0] poly;
    logic [2:0] crc_in;

    logic       busy_a  [ND];
    logic       valid_a [ND];
    logic       ok_a    [ND];
    logic       err_a   [ND];
    logic [2:0] crc_a   [ND];

    int n_checks = 0;
    int n_errors = 0;
    int op_idx   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        crc_sekwencyjny #(
            .WCODE(WCODE),
            .WPOLY(WPOLY),
            .BPC  (1 << g)
        ) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_start(start),
            .i_abort(abort_s),
            .i_mode (mode),
            .i_data (data),
            .i_poly (poly),
            .i_crc  (crc_in),
            .o_busy (busy_a[g]),
            .o_valid(valid_a[g]),
            .o_crc  (crc_a[g]),
            .o_ok   (ok_a[g]),
            .o_err  (err_a[g])
        );
    end

    typedef struct {
        logic       crc;
        logic [7:0] d;
        logic [3:0] p;
        logic [2:0] c;
        logic [2:0] e_crc;
        logic       e_ok;
        logic       e_err;
    } vec_t;

    typedef struct {
        logic [2:0] crc;
        logic       ok;
        logic       err;
    } res_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: classic long division of the integer {data, crc_field} by poly
    function automatic res_t ref_model(input logic m, input logic [7:0] d,
                                       input logic [3:0] p, input logic [2:0] c);
        res_t        res;
        int unsigned v;
        v = {21'd0, d, (m ? c : 3'b000)};
        for (int i = 10; i >= 3; i--) begin
            if (v[i]) v = v ^ (32'(p) << (i - 3));
        end
        res.err = ~p[3];
        res.crc = res.err ? 3'b000 : v[2:0];
        res.ok  = m && (v[2:0] == 3'b000) && !res.err;
        return res;
    endfunction

    // One operation on all instances; checks latency, single pulse, result, busy fall
    task automatic run_op(input logic m, input logic [7:0] d, input logic [3:0] p,
                          input logic [2:0] c, input logic [2:0] e_crc,
                          input logic e_ok, input logic e_err);
        int         vc [ND];
        int         vn [ND];
        logic       ba [ND];
        logic [2:0] rc [ND];
        logic       rok[ND];
        logic       rer[ND];
        int         lat;
        op_idx++;
        for (int g = 0; g < ND; g++) begin
            vc[g] = 0; vn[g] = 0; ba[g] = 1'bx; rc[g] = 3'bx; rok[g] = 1'bx; rer[g] = 1'bx;
        end
        @(negedge clk);
        mode = m; data = d; poly = p; crc_in = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int g = 0; g < ND; g++)
            check($sformatf("op%0d dut%0d busy_after_start", op_idx, g), busy_a[g], 1);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < ND; g++) begin
                if (valid_a[g]) begin
                    vn[g]++; vc[g] = cyc;
                    rc[g] = crc_a[g]; rok[g] = ok_a[g]; rer[g] = err_a[g];
                end else if (vn[g] > 0 && vc[g] == cyc - 1) begin
                    ba[g] = busy_a[g];
                end
            end
        end
        for (int g = 0; g < ND; g++) begin
            lat = e_err ? 1 : (8 >> g) + 1;
            check($sformatf("op%0d dut%0d valid_count", op_idx, g), vn[g], 1);
            check($sformatf("op%0d dut%0d latency", op_idx, g), vc[g], lat);
            check($sformatf("op%0d dut%0d crc", op_idx, g), rc[g], e_crc);
            check($sformatf("op%0d dut%0d ok", op_idx, g), rok[g], e_ok);
            check($sformatf("op%0d dut%0d err", op_idx, g), rer[g], e_err);
            check($sformatf("op%0d dut%0d busy_fall", op_idx, g), ba[g], 0);
        end
    endtask

    initial begin
        res_t r;
        logic m;
        logic [7:0] d;
        logic [3:0] p;
        logic [2:0] c;
        int   nv0, nv2, v1, v2;
        logic [2:0] c1, c2;

        vecs[0] = '{1'b0, 8'hD3, 4'b1011, 3'b000, 3'b011, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hD3, 4'b1011, 3'b011, 3'b000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'hD3, 4'b1011, 3'b010, 3'b001, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 4'b1011, 3'b101, 3'b000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'hD3, 4'b0011, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'hD3, 4'b0011, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h01, 4'b1011, 3'b000, 3'b011, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h01, 4'b1111, 3'b000, 3'b111, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort_s = 1'b0;
        mode = 1'b0; data = '0; poly = '0; crc_in = '0;
        #12;
        for (int g = 0; g < ND; g++) begin
            check($sformatf("reset dut%0d busy", g), busy_a[g], 0);
            check($sformatf("reset dut%0d valid", g), valid_a[g], 0);
            check($sformatf("reset dut%0d crc", g), crc_a[g], 0);
            check($sformatf("reset dut%0d ok", g), ok_a[g], 0);
            check($sformatf("reset dut%0d err", g), err_a[g], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].crc, vecs[i].d, vecs[i].p, vecs[i].c,
                   vecs[i].e_crc, vecs[i].e_ok, vecs[i].e_err);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            p = 4'($urandom);
            if ($urandom_range(0, 7) != 0) p[3] = 1'b1;
            c = 3'($urandom);
            r = ref_model(m, d, p, c);
            run_op(m, d, p, c, r.crc, r.ok, r.err);
        end

        // Abort on the third RUN cycle: no pulse, earlier result retained
        run_op(1'b0, 8'hD3, 4'b1011, 3'b000, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        mode = 1'b0; data = 8'h01; poly = 4'b1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nv0 = 0; nv2 = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 3) begin
                @(negedge clk);
                abort_s = 1'b1;
            end
            @(posedge clk);
            #1;
            if (cyc == 3) begin
                abort_s = 1'b0;
                check("abort busy_low", busy_a[0], 0);
            end
            if (valid_a[0]) nv0++;
            if (valid_a[2]) nv2++;
        end
        check("abort no_valid", nv0, 0);
        check("abort crc_kept", crc_a[0], 3'b011);
        check("abort_in_done no_valid", nv2, 0);
        check("abort_in_done crc_kept", crc_a[2], 3'b011);

        // Start and input changes during RUN are ignored
        @(negedge clk);
        mode = 1'b0; data = 8'hD3; poly = 4'b1011; crc_in = 3'b000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nv0 = 0; v1 = 0; c1 = 3'bx;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(posedge clk);
            #1;
            if (valid_a[0]) begin nv0++; v1 = cyc; c1 = crc_a[0]; end
            if (cyc == 3) begin
                start = 1'b1; mode = 1'b1; data = 8'h01; poly = 4'b1111; crc_in = 3'b111;
            end
            if (cyc == 4) start = 1'b0;
        end
        check("start_in_run valid_count", nv0, 1);
        check("start_in_run latency", v1, 9);
        check("start_in_run crc", c1, 3'b011);
        check("start_in_run ok", ok_a[0], 0);
        repeat (20) @(posedge clk);

        // Back-to-back: second start issued in the first IDLE cycle
        @(negedge clk);
        mode = 1'b0; data = 8'hD3; poly = 4'b1011; crc_in = 3'b000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        v1 = 0; v2 = 0; c1 = 3'bx; c2 = 3'bx;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (v1 != 0 && cyc == v1 + 1) check("b2b busy_new_op", busy_a[0], 1);
            if (valid_a[0]) begin
                if (v1 == 0) begin
                    v1 = cyc; c1 = crc_a[0];
                    check("b2b busy_at_valid", busy_a[0], 1);
                    data = 8'h01; poly = 4'b1111; start = 1'b1;
                end else if (v2 == 0) begin
                    v2 = cyc - 1 - v1 + 1 + v1; c2 = crc_a[0];
                end
            end
        end
        check("b2b first_latency", v1, 9);
        check("b2b spacing", v2 - v1, 10);
        check("b2b crc1", c1, 3'b011);
        check("b2b crc2", c2, 3'b111);
        repeat (20) @(posedge clk);

        // Reset mid-RUN clears outputs asynchronously, then a fresh op works
        @(negedge clk);
        mode = 1'b0; data = 8'h01; poly = 4'b1011; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset busy", busy_a[0], 0);
        check("mid_reset valid", valid_a[0], 0);
        check("mid_reset crc", crc_a[0], 0);
        check("mid_reset ok", ok_a[0], 0);
        check("mid_reset err", err_a[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 8'hD3, 4'b1011, 3'b011, 3'b000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
